// File: rtl/evt_packer.sv
// Event packetizer: snapshots one event's results and serialises them as SW-bit words to the slow FIFO.
// Optional checksum trailer is compiled in with `define PKT_CHECKSUM_EN.
module evt_packer #(
   parameter int              NCH    = 4,
   parameter int              DW     = 16,
   parameter logic [2*DW-1:0] PID    = 32'h4142504d,
   parameter int              FREE_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                evt_rdy,
   input  logic                cal_flag,
   input  logic [DW-1:0]       status,
   input  logic [DW-1:0]       x,
   input  logic [DW-1:0]       y,
   input  logic [DW-1:0]       s,
   input  logic [NCH*2*DW-1:0] power,
   input  logic [NCH*2*DW-1:0] cal_power,
   input  logic [NCH*DW-1:0]   maxv,
   input  logic                rst_evt_cnt,
   input  logic [FREE_W-1:0]   fifo_free,
   output logic                fifo_wr,
   output logic [2*DW-1:0]     fifo_din,
   output logic                busy,
   output logic [15:0]         evt_cnt,
   output logic [15:0]         drop_cnt
);

   localparam int SW  = 2 * DW;
   localparam int NMW = (NCH + 1) / 2;
`ifdef PKT_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif
   localparam int              PKT_LEN = 4 + NCH + NMW + CK;
   localparam int              IW      = $clog2(PKT_LEN + 1);
   localparam logic [IW-1:0]   LEN_I   = IW'(PKT_LEN);
   localparam logic [14:0]     LEN15   = 15'(PKT_LEN);
   localparam logic [31:0]     LEN32   = 32'(PKT_LEN);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t              state_reg;
   logic [IW-1:0]       idx_reg;
   logic                fifo_wr_reg;
   logic [SW-1:0]       fifo_din_reg;
   logic [15:0]         evt_cnt_reg;
   logic [15:0]         drop_cnt_reg;
   logic                cap_cal_reg;
   logic [15:0]         cap_cnt_reg;
   logic [DW-1:0]       cap_x_reg, cap_y_reg, cap_s_reg, cap_status_reg;
   logic [NCH*SW-1:0]   cap_pow_reg;
   logic [NCH*DW-1:0]   cap_maxv_reg;
`ifdef PKT_CHECKSUM_EN
   logic [SW-1:0]       acc_reg;
`endif

   logic [15:0]   evt_base;
   logic [15:0]   drop_base;
   logic          admit;
   logic          drop_evt;
   logic [SW-1:0] word_sel;
   logic [SW-1:0] words [PKT_LEN];

   // Counter clear is applied before any same-cycle event is counted.
   assign evt_base  = rst_evt_cnt ? 16'd0 : evt_cnt_reg;
   assign drop_base = rst_evt_cnt ? 16'd0 : drop_cnt_reg;
   assign admit     = evt_rdy && (state_reg == IDLE) && (32'(fifo_free) >= LEN32);
   assign drop_evt  = evt_rdy && !admit;

   assign words[0] = PID;
   assign words[1] = SW'({cap_cal_reg, LEN15, cap_cnt_reg});
   assign words[2] = {cap_x_reg, cap_y_reg};
   assign words[3] = {cap_s_reg, cap_status_reg};

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_pow
         assign words[4+gi] = cap_pow_reg[gi*SW +: SW];
      end
      for (gi = 0; gi < NMW; gi++) begin : g_max
         if (2*gi + 1 < NCH) begin : g_pair
            assign words[4+NCH+gi] = {cap_maxv_reg[2*gi*DW +: DW], cap_maxv_reg[(2*gi+1)*DW +: DW]};
         end else begin : g_last
            assign words[4+NCH+gi] = {cap_maxv_reg[2*gi*DW +: DW], {DW{1'b0}}};
         end
      end
   endgenerate

`ifdef PKT_CHECKSUM_EN
   assign words[PKT_LEN-1] = acc_reg;
`endif

   always_comb begin
      word_sel = '0;
      for (int i = 0; i < PKT_LEN; i++) begin
         if (idx_reg == IW'(i)) word_sel = words[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         idx_reg        <= '0;
         fifo_wr_reg    <= 1'b0;
         fifo_din_reg   <= '0;
         evt_cnt_reg    <= '0;
         drop_cnt_reg   <= '0;
         cap_cal_reg    <= 1'b0;
         cap_cnt_reg    <= '0;
         cap_x_reg      <= '0;
         cap_y_reg      <= '0;
         cap_s_reg      <= '0;
         cap_status_reg <= '0;
         cap_pow_reg    <= '0;
         cap_maxv_reg   <= '0;
`ifdef PKT_CHECKSUM_EN
         acc_reg        <= '0;
`endif
      end else begin
         evt_cnt_reg  <= evt_base + 16'(evt_rdy && !cal_flag);
         drop_cnt_reg <= (drop_evt && drop_base != 16'hFFFF) ? drop_base + 16'd1 : drop_base;
         case (state_reg)
            IDLE: begin
               fifo_wr_reg <= 1'b0;
               if (admit) begin
                  cap_cal_reg    <= cal_flag;
                  cap_cnt_reg    <= evt_base;
                  cap_x_reg      <= x;
                  cap_y_reg      <= y;
                  cap_s_reg      <= s;
                  cap_status_reg <= status;
                  cap_pow_reg    <= cal_flag ? cal_power : power;
                  cap_maxv_reg   <= maxv;
                  // W0 is constant, so it goes out straight from the admission edge.
                  fifo_wr_reg    <= 1'b1;
                  fifo_din_reg   <= PID;
                  idx_reg        <= IW'(1);
`ifdef PKT_CHECKSUM_EN
                  acc_reg        <= PID;
`endif
                  state_reg      <= EMIT;
               end
            end
            EMIT: begin
               if (idx_reg == LEN_I) begin
                  fifo_wr_reg <= 1'b0;
                  state_reg   <= IDLE;
               end else begin
                  fifo_din_reg <= word_sel;
                  idx_reg      <= idx_reg + 1'b1;
`ifdef PKT_CHECKSUM_EN
                  acc_reg      <= acc_reg ^ word_sel;
`endif
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign fifo_wr  = fifo_wr_reg;
   assign fifo_din = fifo_din_reg;
   assign busy     = fifo_wr_reg;
   assign evt_cnt  = evt_cnt_reg;
   assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_evt_packer.sv
// Bench for evt_packer: queue-based packet model checked every cycle, plus literal pins from worked examples.
module tb_evt_packer;

   localparam int NCH = 4;
   localparam int DW  = 16;
   localparam int SW  = 32;
   localparam int FREE_W = 8;
   localparam logic [31:0] PID = 32'h4142504d;
`ifdef PKT_CHECKSUM_EN
   localparam int CK = 1;
   localparam logic [31:0] W1_LIT = 32'h000B0000;
`else
   localparam int CK = 0;
   localparam logic [31:0] W1_LIT = 32'h000A0000;
`endif
   localparam int PKT_LEN = 4 + NCH + (NCH + 1) / 2 + CK;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                evt_rdy = 1'b0;
   logic                cal_flag = 1'b0;
   logic [DW-1:0]       status = '0, x = '0, y = '0, s = '0;
   logic [NCH*SW-1:0]   power = '0, cal_power = '0;
   logic [NCH*DW-1:0]   maxv = '0;
   logic                rst_evt_cnt = 1'b0;
   logic [FREE_W-1:0]   fifo_free = '0;
   logic                fifo_wr, busy;
   logic [SW-1:0]       fifo_din;
   logic [15:0]         evt_cnt, drop_cnt;

   evt_packer #(.NCH(NCH), .DW(DW), .PID(PID), .FREE_W(FREE_W)) dut (
      .clk(clk), .rst(rst), .evt_rdy(evt_rdy), .cal_flag(cal_flag),
      .status(status), .x(x), .y(y), .s(s),
      .power(power), .cal_power(cal_power), .maxv(maxv),
      .rst_evt_cnt(rst_evt_cnt), .fifo_free(fifo_free),
      .fifo_wr(fifo_wr), .fifo_din(fifo_din), .busy(busy),
      .evt_cnt(evt_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit check_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: a packet is a list of words queued at admission and drained one per cycle.
   logic [31:0] m_q [$];
   logic        m_wr = 1'b0;
   logic [31:0] m_din = '0;
   logic [15:0] m_evt = '0, m_drop = '0;
   bit          m_after_rst = 1'b0;

   function automatic void make_packet(input logic [15:0] snap);
      logic [31:0] pk [$];
      logic [31:0] xr;
      logic [NCH*SW-1:0] pw;
      logic [15:0] lo;
      pw = cal_flag ? cal_power : power;
      pk.push_back(PID);
      pk.push_back({cal_flag, 15'(PKT_LEN), snap});
      pk.push_back({x, y});
      pk.push_back({s, status});
      for (int ch = 0; ch < NCH; ch++) pk.push_back(pw[ch*SW +: SW]);
      for (int k = 0; k < NCH; k += 2) begin
         lo = (k + 1 < NCH) ? maxv[(k+1)*DW +: DW] : 16'h0;
         pk.push_back({maxv[k*DW +: DW], lo});
      end
      if (CK == 1) begin
         xr = '0;
         foreach (pk[i]) xr ^= pk[i];
         pk.push_back(xr);
      end
      foreach (pk[i]) m_q.push_back(pk[i]);
   endfunction

   always @(posedge clk) begin : model
      logic [15:0] eb, db;
      bit busy_now;
      busy_now = m_wr;
      if (rst) begin
         m_q.delete();
         m_evt = '0; m_drop = '0; m_wr = 1'b0; m_din = '0;
         m_after_rst = 1'b1;
      end else begin
         m_after_rst = 1'b0;
         eb = rst_evt_cnt ? 16'h0 : m_evt;
         db = rst_evt_cnt ? 16'h0 : m_drop;
         if (evt_rdy) begin
            if (!busy_now && int'(fifo_free) >= PKT_LEN) make_packet(eb);
            else if (db != 16'hFFFF) db = db + 16'd1;
            if (!cal_flag) eb = eb + 16'd1;
         end
         m_evt = eb;
         m_drop = db;
         if (m_q.size() > 0) begin
            m_wr = 1'b1;
            m_din = m_q.pop_front();
         end else begin
            m_wr = 1'b0;
         end
      end
   end

   logic [31:0] cap [$];

   always @(negedge clk) begin
      if (check_en) begin
         chk("fifo_wr", 64'(fifo_wr), 64'(m_wr));
         chk("busy", 64'(busy), 64'(m_wr));
         if (m_wr || m_after_rst) chk("fifo_din", 64'(fifo_din), 64'(m_din));
         chk("evt_cnt", 64'(evt_cnt), 64'(m_evt));
         chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      end
      if (fifo_wr) cap.push_back(fifo_din);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fire(input logic cal, input logic [FREE_W-1:0] free);
      evt_rdy = 1'b1;
      cal_flag = cal;
      fifo_free = free;
      step();
      evt_rdy = 1'b0;
      cal_flag = 1'b0;
      rst_evt_cnt = 1'b0;
   endtask

   logic [31:0] lit [10];

   initial begin
      lit = '{32'h4142504d, W1_LIT, 32'h12345678, 32'h00AA0001, 32'h1, 32'h2, 32'h3, 32'h4,
              32'h01000101, 32'h01020103};
      x = 16'h1234; y = 16'h5678; s = 16'h00AA; status = 16'h0001;
      power = {32'd4, 32'd3, 32'd2, 32'd1};
      cal_power = {32'hCA000004, 32'hCA000003, 32'hCA000002, 32'hCA000001};
      maxv = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
      rst = 1'b1;
      step();
      check_en = 1'b1;
      repeat (2) step();
      rst = 1'b0;

      // Real event from reset
      cap.delete();
      fire(1'b0, 8'd64);
      repeat (PKT_LEN + 2) step();
      chk("real_len", 64'(cap.size()), 64'(PKT_LEN));
      for (int i = 0; i < 10; i++) chk($sformatf("real_w%0d", i), 64'(cap[i]), 64'(lit[i]));
      chk("real_evt_cnt", 64'(evt_cnt), 64'd1);
      $display("txn real event: %0d words, evt_cnt=%0d", cap.size(), evt_cnt);

      // Cal event with same-cycle counter clear
      cap.delete();
      rst_evt_cnt = 1'b1;
      fire(1'b1, 8'd64);
      repeat (PKT_LEN + 2) step();
      chk("cal_w1", 64'(cap[1]), 64'(W1_LIT | 32'h80000000));
      chk("cal_w4", 64'(cap[4]), 64'h00000000CA000001);
      chk("cal_w7", 64'(cap[7]), 64'h00000000CA000004);
      chk("cal_evt_cnt", 64'(evt_cnt), 64'd0);
      $display("txn cal event: w1=%h evt_cnt=%0d", cap[1], evt_cnt);

      // Insufficient room
      cap.delete();
      fire(1'b0, 8'(PKT_LEN - 1));
      repeat (3) step();
      chk("drop_writes", 64'(cap.size()), 64'd0);
      chk("drop_drop_cnt", 64'(drop_cnt), 64'd1);
      chk("drop_evt_cnt", 64'(evt_cnt), 64'd1);
      $display("txn low-room drop: drop_cnt=%0d evt_cnt=%0d", drop_cnt, evt_cnt);

      // Spacing: t accepted (with clear), t+PKT_LEN dropped, t+PKT_LEN+1 accepted
      cap.delete();
      rst_evt_cnt = 1'b1;
      fire(1'b0, 8'd64);
      repeat (PKT_LEN - 1) step();
      fire(1'b0, 8'd64);
      fire(1'b0, 8'd64);
      repeat (PKT_LEN + 2) step();
      chk("space_len", 64'(cap.size()), 64'(2 * PKT_LEN));
      chk("space_cnt0", 64'(cap[1][15:0]), 64'd0);
      chk("space_cnt2", 64'(cap[PKT_LEN+1][15:0]), 64'd2);
      chk("space_drop", 64'(drop_cnt), 64'd1);
      $display("txn spacing: %0d words, drop_cnt=%0d", cap.size(), drop_cnt);

      // Reset while word 5 is on the bus
      cap.delete();
      fire(1'b0, 8'd64);
      repeat (5) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_wr", 64'(fifo_wr), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_evt", 64'(evt_cnt), 64'd0);
      chk("rst_words", 64'(cap.size()), 64'd6);
      fire(1'b0, 8'd64);
      repeat (PKT_LEN + 2) step();
      chk("post_rst_len", 64'(cap.size()), 64'(6 + PKT_LEN));
      chk("post_rst_cnt", 64'(cap[7][15:0]), 64'd0);
      $display("txn reset mid-packet: %0d words captured", cap.size());

      // Randomised traffic; inputs change every cycle to exercise capture immunity
      for (int i = 0; i < 3000; i++) begin
         x = 16'($urandom); y = 16'($urandom); s = 16'($urandom); status = 16'($urandom);
         power = {$urandom, $urandom, $urandom, $urandom};
         cal_power = {$urandom, $urandom, $urandom, $urandom};
         maxv = {$urandom, $urandom};
         evt_rdy = ($urandom_range(0, 5) == 0);
         cal_flag = ($urandom_range(0, 3) == 0);
         fifo_free = 8'($urandom_range(0, 3 * PKT_LEN));
         rst_evt_cnt = ($urandom_range(0, 49) == 0);
         rst = ($urandom_range(0, 499) == 0);
         step();
      end
      evt_rdy = 1'b0; rst = 1'b0; rst_evt_cnt = 1'b0;
      repeat (PKT_LEN + 2) step();
      $display("txn random phase done: evt_cnt=%0d drop_cnt=%0d", evt_cnt, drop_cnt);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
